altram_bus_ctrl: RTL and testbench

- Parametrised successor to the single-window alt-RAM glue on the 68k booster.
- Synchronises the CPU bus strobe into the CLKOSC domain and decodes up to three 4 MB alt-RAM windows, with a ROM-shadow remap and an address-encoded config register.
- Sequences each claimed cycle through an FSM that drives the SDRAM core select, generates DTACK after the SDRAM reports valid, and raises BERR on timeout.
- Sits between the CPU pins and nouveau_sdram, replacing the ad-hoc AS-edge logic.

---
 rtl/altram_pkg.sv | 20 ++
 rtl/altram_decode.sv | 29 ++
 rtl/altram_bus_ctrl.sv | 155 +++++++++++++++
 tb/tb_altram_bus_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/altram_pkg.sv
// Shared types and constants for the alt-RAM bus controller and its address classifier.
package altram_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_CFG, ST_WAIT, ST_ACK, ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE, CLS_CFG, CLS_ROM, CLS_WIN
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [1:0] win_idx;
    } dec_t;

    localparam logic [2:0] CMD_DISABLE_ALL   = 3'h6;
    localparam logic [2:0] CMD_ROM_ON        = 3'h7;
    localparam logic [3:0] ROM_REMAP_NIBBLE  = 4'hB;
    localparam logic [3:0] ROM_SHADOW_NIBBLE = 4'hE;
endpackage

// File: rtl/altram_decode.sv
// Combinational address classifier: config block, ROM shadow, alt-RAM windows, or unclaimed.
module altram_decode import altram_pkg::*; #(
    parameter int          NUM_WIN  = 2,
    parameter logic [19:0] CFG_BASE = 20'hFFFE0
) (
    input  logic [23:1]        a,
    input  logic [NUM_WIN-1:0] win_en,
    input  logic               rom_en,
    output dec_t               dec
);
    logic [NUM_WIN-1:0] hit;

    // Window i occupies the 4 MB slot A[23:22] == i+1; slot 0 is the motherboard.
    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        assign hit[i] = win_en[i] && (a[23:22] == 2'(i + 1));
    end

    always_comb begin
        dec = '{cls: CLS_NONE, win_idx: 2'd0};
        for (int i = 0; i < NUM_WIN; i++)
            if (hit[i]) dec.win_idx = 2'(i);
        if (a[23:4] == CFG_BASE)
            dec.cls = CLS_CFG;
        else if (rom_en && a[23:20] == ROM_SHADOW_NIBBLE)
            dec.cls = CLS_ROM;
        else if (|hit)
            dec.cls = CLS_WIN;
    end
endmodule

// File: rtl/altram_bus_ctrl.sv
// 68k bus-cycle sequencer for alt-RAM: AS_n synchroniser, decode, SDRAM select, DTACK/BERR generation.
module altram_bus_ctrl import altram_pkg::*; #(
    parameter int          NUM_WIN     = 2,
    parameter logic [19:0] CFG_BASE    = 20'hFFFE0,
    parameter int          CFG_WAIT    = 2,
    parameter int          TIMEOUT     = 255,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               CLKOSC,
    input  logic               RST,
    input  logic               AS_n,
    input  logic               RW,
    input  logic               UDS_n,
    input  logic               LDS_n,
    input  logic [23:1]        A,
    input  logic               SDRAM_VALID_n,
    output logic               ALT_SEL_n,
    output logic               ROM_REMAP,
    output logic               DTACK_n,
    output logic               DTACK_OE,
    output logic               BERR_n,
    output logic               BERR_OE,
    output logic [NUM_WIN-1:0] WIN_EN,
    output logic               ROM_EN
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] as_pipe;
    logic                   as_s;
    state_t                 state, state_nxt;
    cls_t                   cls_q, cls_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [2:0]             cmd_q, cmd_nxt;
    logic [NUM_WIN-1:0]     win_en_nxt;
    logic                   rom_en_nxt;
    logic                   neg_dt, neg_be, neg_dt_nxt, neg_be_nxt;
    dec_t                   dec;
    logic                   unused_ok;

    assign as_s = as_pipe[SYNC_STAGES-1];

    // Commands fire on reads and writes alike, so direction and strobes are not needed here.
    assign unused_ok = ^{RW, UDS_n, LDS_n, dec.win_idx, ROM_REMAP_NIBBLE};

    altram_decode #(.NUM_WIN(NUM_WIN), .CFG_BASE(CFG_BASE)) u_decode (
        .a      (A),
        .win_en (WIN_EN),
        .rom_en (ROM_EN),
        .dec    (dec)
    );

    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            as_pipe <= '1;
            state   <= ST_IDLE;
            cls_q   <= CLS_NONE;
            cnt     <= '0;
            cmd_q   <= '0;
            WIN_EN  <= '0;
            ROM_EN  <= 1'b0;
            neg_dt  <= 1'b0;
            neg_be  <= 1'b0;
        end else begin
            as_pipe <= {as_pipe[SYNC_STAGES-2:0], AS_n};
            state   <= state_nxt;
            cls_q   <= cls_nxt;
            cnt     <= cnt_nxt;
            cmd_q   <= cmd_nxt;
            WIN_EN  <= win_en_nxt;
            ROM_EN  <= rom_en_nxt;
            neg_dt  <= neg_dt_nxt;
            neg_be  <= neg_be_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cls_nxt    = cls_q;
        cnt_nxt    = cnt;
        cmd_nxt    = cmd_q;
        win_en_nxt = WIN_EN;
        rom_en_nxt = ROM_EN;
        neg_dt_nxt = 1'b0;
        neg_be_nxt = 1'b0;
        ALT_SEL_n  = 1'b1;
        ROM_REMAP  = 1'b0;
        DTACK_n    = 1'b1;
        BERR_n     = 1'b1;
        // One IDLE cycle after ACK/ERR keeps the driver on to actively negate the line.
        DTACK_OE   = neg_dt;
        BERR_OE    = neg_be;
        case (state)
            ST_IDLE: if (!as_s) state_nxt = ST_DECODE;
            ST_DECODE: begin
                cls_nxt = dec.cls;
                cmd_nxt = A[3:1];
                case (dec.cls)
                    CLS_CFG: begin
                        state_nxt = ST_CFG;
                        cnt_nxt   = CNT_W'(CFG_WAIT);
                    end
                    CLS_ROM, CLS_WIN: begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                    end
                    default: if (as_s) state_nxt = ST_IDLE;
                endcase
            end
            ST_CFG: begin
                if (as_s) begin
                    state_nxt = ST_IDLE;
                end else if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_ACK;
                    for (int i = 0; i < NUM_WIN; i++)
                        if (cmd_q == 3'(i)) win_en_nxt[i] = 1'b1;
                    if (cmd_q == CMD_DISABLE_ALL) begin
                        win_en_nxt = '0;
                        rom_en_nxt = 1'b0;
                    end
                    if (cmd_q == CMD_ROM_ON) rom_en_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                ALT_SEL_n = 1'b0;
                ROM_REMAP = (cls_q == CLS_ROM);
                // Valid is tested before the timeout so a last-cycle response still acks.
                if (as_s)                            state_nxt = ST_IDLE;
                else if (!SDRAM_VALID_n)             state_nxt = ST_ACK;
                else if (cnt == CNT_W'(TIMEOUT - 1)) state_nxt = ST_ERR;
                else                                 cnt_nxt   = cnt + CNT_W'(1);
            end
            ST_ACK: begin
                DTACK_OE  = 1'b1;
                DTACK_n   = 1'b0;
                ALT_SEL_n = (cls_q == CLS_CFG);
                ROM_REMAP = (cls_q == CLS_ROM);
                if (as_s) begin
                    state_nxt  = ST_IDLE;
                    neg_dt_nxt = 1'b1;
                end
            end
            ST_ERR: begin
                BERR_OE = 1'b1;
                BERR_n  = 1'b0;
                if (as_s) begin
                    state_nxt  = ST_IDLE;
                    neg_be_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_altram_bus_ctrl.sv
// Directed bench for altram_bus_ctrl: default build plus NUM_WIN=3 and NUM_WIN=1 builds on shared pins.
module tb_altram_bus_ctrl;
    logic        CLKOSC = 1'b0;
    logic        RST = 1'b0, AS_n = 1'b1, RW = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1;
    logic        SDRAM_VALID_n = 1'b1;
    logic [23:1] A = '0;

    // bus = {ALT_SEL_n, ROM_REMAP, DTACK_n, DTACK_OE, BERR_n, BERR_OE}
    wire [5:0] bus1, bus2, bus3;
    wire [0:0] win1;
    wire [1:0] win2;
    wire [2:0] win3;
    wire       rom1, rom2, rom3;

    localparam logic [5:0] B_REL  = 6'b101010;
    localparam logic [5:0] B_SEL  = 6'b001010;
    localparam logic [5:0] B_SELR = 6'b011010;
    localparam logic [5:0] B_ACKS = 6'b000110;
    localparam logic [5:0] B_ACKR = 6'b010110;
    localparam logic [5:0] B_ACKC = 6'b100110;
    localparam logic [5:0] B_NEGD = 6'b101110;
    localparam logic [5:0] B_BERR = 6'b101001;
    localparam logic [5:0] B_NEGB = 6'b101011;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLKOSC = ~CLKOSC;

    altram_bus_ctrl #(.NUM_WIN(2)) d2 (
        .CLKOSC(CLKOSC), .RST(RST), .AS_n(AS_n), .RW(RW), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .A(A), .SDRAM_VALID_n(SDRAM_VALID_n),
        .ALT_SEL_n(bus2[5]), .ROM_REMAP(bus2[4]), .DTACK_n(bus2[3]), .DTACK_OE(bus2[2]),
        .BERR_n(bus2[1]), .BERR_OE(bus2[0]), .WIN_EN(win2), .ROM_EN(rom2));

    altram_bus_ctrl #(.NUM_WIN(3)) d3 (
        .CLKOSC(CLKOSC), .RST(RST), .AS_n(AS_n), .RW(RW), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .A(A), .SDRAM_VALID_n(SDRAM_VALID_n),
        .ALT_SEL_n(bus3[5]), .ROM_REMAP(bus3[4]), .DTACK_n(bus3[3]), .DTACK_OE(bus3[2]),
        .BERR_n(bus3[1]), .BERR_OE(bus3[0]), .WIN_EN(win3), .ROM_EN(rom3));

    altram_bus_ctrl #(.NUM_WIN(1)) d1 (
        .CLKOSC(CLKOSC), .RST(RST), .AS_n(AS_n), .RW(RW), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .A(A), .SDRAM_VALID_n(SDRAM_VALID_n),
        .ALT_SEL_n(bus1[5]), .ROM_REMAP(bus1[4]), .DTACK_n(bus1[3]), .DTACK_OE(bus1[2]),
        .BERR_n(bus1[1]), .BERR_OE(bus1[0]), .WIN_EN(win1), .ROM_EN(rom1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens 2 time units after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLKOSC);
        #2;
    endtask

    task automatic begin_cyc(input logic [23:0] addr);
        A     = addr[23:1];
        RW    = 1'b1;
        UDS_n = 1'b0;
        LDS_n = 1'b0;
        AS_n  = 1'b0;
    endtask

    task automatic end_cyc();
        AS_n  = 1'b1;
        UDS_n = 1'b1;
        LDS_n = 1'b1;
    endtask

    // Edge 3 = DECODE, edges 4-5 = CFG, edge 6 = ACK.
    task automatic cfg_cyc(input logic [23:0] addr);
        begin_cyc(addr);
        step(5); chk($sformatf("cfg_%h_pre", addr), bus2, B_REL);
        step(1); chk($sformatf("cfg_%h_ack", addr), bus2, B_ACKC);
        end_cyc();
        step(2); chk($sformatf("cfg_%h_hold", addr), bus2, B_ACKC);
        step(1); chk($sformatf("cfg_%h_neg", addr), bus2, B_NEGD);
        step(1); chk($sformatf("cfg_%h_rel", addr), bus2, B_REL);
    endtask

    initial begin
        step(3);
        chk("rst_bus", bus2, B_REL);
        chk("rst_win", win2, 8'h0);
        chk("rst_rom", rom2, 8'h0);
        RST = 1'b1;
        step(2);

        // Window disabled: cycle must stay unclaimed.
        begin_cyc(24'h400000);
        step(5); chk("unclaimed_400000", bus2, B_REL);
        end_cyc();
        step(4); chk("unclaimed_after", bus2, B_REL);

        cfg_cyc(24'hFFFE00);
        chk("win0_on", win2, 8'h1);

        // Window read: ALT_SEL_n at edge 4, valid seen at edge 8.
        begin_cyc(24'h400000);
        step(3); chk("win_decode", bus2, B_REL);
        step(1); chk("win_sel", bus2, B_SEL);
        step(3); chk("win_sel_hold", bus2, B_SEL);
        SDRAM_VALID_n = 1'b0;
        step(1); chk("win_ack", bus2, B_ACKS);
        SDRAM_VALID_n = 1'b1;
        end_cyc();
        step(2); chk("win_ack_hold", bus2, B_ACKS);
        step(1); chk("win_neg", bus2, B_NEGD);
        step(1); chk("win_rel", bus2, B_REL);

        cfg_cyc(24'hFFFE0E);
        chk("rom_on", rom2, 8'h1);
        begin_cyc(24'hE00100);
        step(4); chk("rom_sel", bus2, B_SELR);
        SDRAM_VALID_n = 1'b0;
        step(1); chk("rom_ack", bus2, B_ACKR);
        SDRAM_VALID_n = 1'b1;
        end_cyc();
        step(3); chk("rom_neg", bus2, B_NEGD);
        step(1); chk("rom_rel", bus2, B_REL);

        cfg_cyc(24'hFFFE0C);
        chk("disable_win", win2, 8'h0);
        chk("disable_rom", rom2, 8'h0);
        begin_cyc(24'hE00100);
        step(4); chk("rom_off_unclaimed", bus2, B_REL);
        end_cyc();
        step(4);
        cfg_cyc(24'hFFFE00);

        // Timeout: WAIT spans edges 4..258, BERR after edge 259.
        begin_cyc(24'h400000);
        step(4);
        step(254); chk("to_last_wait", bus2, B_SEL);
        step(1); chk("to_berr", bus2, B_BERR);
        end_cyc();
        step(2); chk("to_berr_hold", bus2, B_BERR);
        step(1); chk("to_neg", bus2, B_NEGB);
        step(1); chk("to_rel", bus2, B_REL);

        // Valid on the 255th WAIT cycle wins over the timeout.
        begin_cyc(24'h400000);
        step(4);
        step(254);
        SDRAM_VALID_n = 1'b0;
        step(1); chk("to_edge_ack", bus2, B_ACKS);
        SDRAM_VALID_n = 1'b1;
        end_cyc();
        step(3); chk("to_edge_neg", bus2, B_NEGD);
        step(1); chk("to_edge_rel", bus2, B_REL);

        // Abort mid-WAIT.
        begin_cyc(24'h400000);
        step(10); chk("abort_sel", bus2, B_SEL);
        end_cyc();
        step(2); chk("abort_pending", bus2, B_SEL);
        step(1); chk("abort_rel", bus2, B_REL);
        step(1); chk("abort_no_ack", bus2, B_REL);

        // Reset asserted mid-ACK releases everything at once.
        begin_cyc(24'h400000);
        step(4);
        SDRAM_VALID_n = 1'b0;
        step(1); chk("rstack_ack", bus2, B_ACKS);
        #1 RST = 1'b0;
        #1;
        chk("rstack_bus", bus2, B_REL);
        chk("rstack_win", win2, 8'h0);
        SDRAM_VALID_n = 1'b1;
        end_cyc();
        step(2);
        RST = 1'b1;
        step(2);

        // Window 2 exists only in the NUM_WIN=3 build.
        cfg_cyc(24'hFFFE04);
        chk("nw3_win", win3, 8'h4);
        chk("nw2_win", win2, 8'h0);
        chk("nw1_win", win1, 8'h0);
        begin_cyc(24'hC00000);
        step(4);
        chk("nw3_c00000", bus3, B_SEL);
        chk("nw2_c00000", bus2, B_REL);
        chk("nw1_c00000", bus1, B_REL);
        end_cyc();
        step(3); chk("nw3_abort", bus3, B_REL);

        cfg_cyc(24'hFFFE02);
        chk("nw2_win1", win2, 8'h2);
        chk("nw1_win1", win1, 8'h0);
        chk("nw3_win1", win3, 8'h6);
        begin_cyc(24'h800000);
        step(4);
        chk("nw2_800000", bus2, B_SEL);
        chk("nw1_800000", bus1, B_REL);
        chk("nw3_800000", bus3, B_SEL);
        end_cyc();
        step(3); chk("nw2_abort", bus2, B_REL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
